mem_stage: RTL

Memory-access stage of the 32-bit RISC-V pipeline, directly downstream of the EX stage. It consumes the EX/MEM outputs (`ctrl_mem`, `rd_mem`, `pc4_mem`, `alu_result`, `write_data1`) and issues word loads/stores over a ready/request data-memory handshake. It stalls upstream while an access is outstanding and registers the results into the MEM/WB pipeline register. Misaligned and timed-out accesses become bubbles with a sticky error flag.

---
 rtl/riscv_pkg.sv | 27 ++
 rtl/mem_wb_reg.sv | 49 ++++
 rtl/mem_stage.sv | 121 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the pipeline: EX/MEM control layout, write-back select
// encodings, MEM-stage FSM states and the default memory timeout.
package riscv_pkg;

    // ctrl_mem bit positions
    localparam int unsigned CTRL_REG_WRITE = 4;
    localparam int unsigned CTRL_MTR_HI    = 3;
    localparam int unsigned CTRL_MTR_LO    = 2;
    localparam int unsigned CTRL_MEM_READ  = 1;
    localparam int unsigned CTRL_MEM_WRITE = 0;

    // mem_to_reg encodings; 2'b11 falls back to the ALU value
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    // Width of the MEM/WB control field: reg_write + mem_to_reg
    localparam int unsigned CTRL_WB_W = 3;

    localparam int unsigned TIMEOUT_DEFAULT = 16;

    typedef enum logic {
        StIdle,
        StBusy
    } mem_state_e;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A bubble loads all-zero so WB sees a no-op.
module mem_wb_reg
    import riscv_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bubble_i,
    input  logic [CTRL_WB_W-1:0] ctrl_i,
    input  logic [31:0]          rd_i,
    input  logic [31:0]          data_i,
    output logic [CTRL_WB_W-1:0] ctrl_o,
    output logic [31:0]          rd_o,
    output logic [31:0]          data_o
);

    logic [CTRL_WB_W-1:0] ctrl_q, ctrl_d;
    logic [31:0]          rd_q, rd_d;
    logic [31:0]          data_q, data_d;

    // Select real values or a bubble for the next MEM/WB contents
    always_comb begin
        ctrl_d = ctrl_i;
        rd_d   = rd_i;
        data_d = data_i;
        if (bubble_i) begin
            ctrl_d = '0;
            rd_d   = '0;
            data_d = '0;
        end
    end

    // Pipeline register, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q <= '0;
            rd_q   <= '0;
            data_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            rd_q   <= rd_d;
            data_q <= data_d;
        end
    end

    assign ctrl_o = ctrl_q;
    assign rd_o   = rd_q;
    assign data_o = data_q;

endmodule

// File: rtl/mem_stage.sv
// MEM stage: issues word loads/stores over a req/ready handshake, stalls the
// front of the pipe while an access is outstanding and feeds MEM/WB.
module mem_stage
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           ctrl_mem,
    input  logic [31:0]          rd_mem,
    input  logic [31:0]          pc4_mem,
    input  logic [31:0]          alu_result,
    input  logic [31:0]          write_data1,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [31:0]          dmem_addr,
    output logic [31:0]          dmem_wdata,
    input  logic                 dmem_ready,
    input  logic [31:0]          dmem_rdata,
    output logic                 stall,
    output logic [CTRL_WB_W-1:0] ctrl_wb,
    output logic [31:0]          rd_wb,
    output logic [31:0]          wb_data,
    output logic                 mem_err
);

    localparam int unsigned     CntW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

    mem_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            mem_err_q, mem_err_d;

    logic            mem_op;
    logic            misaligned;
    logic            abort;
    logic            bubble;
    logic [1:0]      mem_to_reg;
    logic [31:0]     wb_sel;

    // Decode the EX/MEM instruction and drive the memory port
    always_comb begin
        mem_op     = ctrl_mem[CTRL_MEM_READ] | ctrl_mem[CTRL_MEM_WRITE];
        misaligned = mem_op & (alu_result[1:0] != 2'b00);
        dmem_req   = mem_op & ~misaligned;
        // Abort only when ready is absent in the last allowed cycle
        abort      = dmem_req & (state_q == StBusy) & (cnt_q == CntMax) & ~dmem_ready;
        stall      = dmem_req & ~dmem_ready & ~abort;
        // mem_write wins over mem_read, so the write bit alone picks a store
        dmem_we    = dmem_req & ctrl_mem[CTRL_MEM_WRITE];
        dmem_addr  = dmem_req ? alu_result : '0;
        dmem_wdata = dmem_req ? write_data1 : '0;
        bubble     = stall | misaligned | abort;
    end

    // FSM / wait-counter next state and sticky error
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_err_d = mem_err_q | misaligned | abort;
        unique case (state_q)
            StIdle: begin
                if (dmem_req && !dmem_ready) begin
                    state_d = StBusy;
                    cnt_d   = '0;
                end
            end
            StBusy: begin
                if (!dmem_req || dmem_ready || abort) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Write-back value select
    always_comb begin
        mem_to_reg = ctrl_mem[CTRL_MTR_HI:CTRL_MTR_LO];
        case (mem_to_reg)
            WB_MEM:  wb_sel = dmem_rdata;
            WB_PC4:  wb_sel = pc4_mem;
            default: wb_sel = alu_result;
        endcase
    end

    // FSM, counter and error flag state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign mem_err = mem_err_q;

    mem_wb_reg u_mem_wb_reg (
        .clk      (clk),
        .reset    (reset),
        .bubble_i (bubble),
        .ctrl_i   ({ctrl_mem[CTRL_REG_WRITE], mem_to_reg}),
        .rd_i     (rd_mem),
        .data_i   (wb_sel),
        .ctrl_o   (ctrl_wb),
        .rd_o     (rd_wb),
        .data_o   (wb_data)
    );

endmodule
